// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, framebuffer types and slot encoding
// Contents: 640x480 active area within an 800x525 frame, 320x240 framebuffer
// geometry, pixel/address types, slot owner enum, pipeline tag struct and an
// active-area helper.
package vga_pkg;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    localparam int FB_W    = 320;
    localparam int FB_H    = 240;
    localparam int FB_SIZE = FB_W * FB_H;

    typedef logic [7:0]  pixel_t;
    typedef logic [16:0] vaddr_t;

    typedef enum logic [1:0] {
        SLOT_DISPLAY,
        SLOT_WRITE,
        SLOT_IDLE
    } slot_e;

    // One entry per pipeline stage: is the pixel on screen, and does this
    // stage carry freshly read RAM data (even column) or a hold cycle.
    typedef struct packed {
        logic active;
        logic load;
    } tag_t;

    function automatic logic is_active(input logic [9:0] h, input logic [9:0] v);
        return (h < H_ACTIVE) && (v < V_ACTIVE);
    endfunction
endpackage

// File: rtl/vga_fb_addr.sv
// rtl/vga_fb_addr.sv - framebuffer row/column to linear address, row*320+col
// Ports: row, col - halved vertical/horizontal counters (stored pixel coords);
//        addr     - linear RAM address.
module vga_fb_addr #(
    parameter int ADDR_W = 17
) (
    input  logic [8:0]        row,
    input  logic [8:0]        col,
    output logic [ADDR_W-1:0] addr
);
    // row*320 = row*256 + row*64
    assign addr = ADDR_W'({row, 8'b0}) + ADDR_W'({row, 6'b0}) + ADDR_W'(col);
endmodule

// File: rtl/vga_vram_arbiter.sv
// rtl/vga_vram_arbiter.sv - single-port VRAM shared by display fetch and pixel writer
// Ports: Clock25/Reset - pixel clock, sync active-high reset;
//        HorizontalCounter/VerticalCounter - raster position from vga_sync;
//        MemAddr/MemWe/MemWData/MemRData - registered RAM command, read data 1 cycle later;
//        WriteReq/WriteAddr/WriteData/WriteAck/WriteDropped - writer handshake;
//        PixelOut/PixelValid - display pixel, 3 cycles behind the counters.
module vga_vram_arbiter #(
    parameter int FB_W                = 320,
    parameter int FB_H                = 240,
    parameter int ADDR_W              = 17,
    parameter int DATA_W              = 8,
    parameter int WRITE_IN_BLANK_ONLY = 0
) (
    input  logic              Clock25,
    input  logic              Reset,
    input  logic [9:0]        HorizontalCounter,
    input  logic [9:0]        VerticalCounter,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              WriteReq,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              WriteAck,
    output logic              WriteDropped,
    output logic [DATA_W-1:0] PixelOut,
    output logic              PixelValid
);
    import vga_pkg::*;

    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_W * FB_H);

    logic              active;
    logic              in_range;
    logic [ADDR_W-1:0] disp_addr;
    slot_e             slot;
    tag_t [1:0]        tags;

    vga_fb_addr #(.ADDR_W(ADDR_W)) u_fb_addr (
        .row  (VerticalCounter[9:1]),
        .col  (HorizontalCounter[9:1]),
        .addr (disp_addr)
    );

    assign active   = is_active(HorizontalCounter, VerticalCounter);
    assign in_range = WriteAddr < FB_LIMIT;

    // Display owns every even column of the active area; all else is free.
    always_comb begin
        slot = SLOT_IDLE;
        if (active && !HorizontalCounter[0]) begin
            slot = SLOT_DISPLAY;
        end else if (WriteReq && ((WRITE_IN_BLANK_ONLY == 0) || !active)) begin
            slot = SLOT_WRITE;
        end
    end

    always_ff @(posedge Clock25) begin
        if (Reset) begin
            MemAddr      <= '0;
            MemWe        <= 1'b0;
            MemWData     <= '0;
            WriteAck     <= 1'b0;
            WriteDropped <= 1'b0;
            PixelOut     <= '0;
            PixelValid   <= 1'b0;
            tags         <= '0;
        end else begin
            MemWe        <= 1'b0;
            WriteAck     <= 1'b0;
            WriteDropped <= 1'b0;
            case (slot)
                SLOT_DISPLAY: MemAddr <= disp_addr;
                SLOT_WRITE: begin
                    MemAddr      <= WriteAddr;
                    MemWData     <= WriteData;
                    MemWe        <= in_range;
                    WriteAck     <= 1'b1;
                    WriteDropped <= !in_range;
                end
                default: ;
            endcase

            // Stage 0: command issued; stage 1: RAM data on MemRData.
            tags[0].active <= active;
            tags[0].load   <= (slot == SLOT_DISPLAY);
            tags[1]        <= tags[0];

            PixelValid <= tags[1].active;
            if (tags[1].load) begin
                PixelOut <= MemRData;
            end else if (!tags[1].active) begin
                PixelOut <= '0;
            end
        end
    end
endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port synchronous video RAM, 320x240 at 8 bpp, between two users.
- The display fetch path is driven by the VGA horizontal/vertical counters and has absolute priority.
- A pixel writer (drawing engine or CPU) uses a req/ack handshake and gets every slot the display does not need.
- Sits between vga_sync (counters) and the RGB output stage; each stored pixel is shown as a 2x2 block on the 640x480 screen.

Parameters:
- FB_W, 320, framebuffer width in stored pixels.
- FB_H, 240, framebuffer height in stored pixels.
- ADDR_W, 17, RAM address width.
- DATA_W, 8, pixel width.
- WRITE_IN_BLANK_ONLY, 0, if 1 the writer is served only outside the 640x480 active area.

Ports:
- Clock25  in  1  pixel clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- HorizontalCounter  in  10  horizontal position from vga_sync, 0..799.
- VerticalCounter  in  10  vertical position from vga_sync, 0..524.
- MemAddr  out  ADDR_W  RAM address.
- MemWe  out  1  RAM write enable.
- MemWData  out  DATA_W  RAM write data.
- MemRData  in  DATA_W  RAM read data, valid 1 cycle after the address.
- WriteReq  in  1  writer request; held with address and data until acked.
- WriteAddr  in  ADDR_W  linear pixel address, y*320+x.
- WriteData  in  DATA_W  pixel value.
- WriteAck  out  1  one-cycle pulse: request consumed.
- WriteDropped  out  1  one-cycle pulse with WriteAck when WriteAddr >= FB_W*FB_H.
- PixelOut  out  DATA_W  pixel for display.
- PixelValid  out  1  PixelOut belongs to the active area.

Behaviour:
- Interface: one clock (Clock25); reset is synchronous and active-high (Reset).
- Active region: H < 640 and V < 480. Display slot: active AND H[0] == 0. Every other cycle is a free slot.
- Each cycle the slot owner is decided combinationally from the input counters. Mem* outputs are registered, so the RAM sees the command one cycle later.
- Display slot:
  - MemAddr <= (V>>1)*320 + (H>>1), computed as {row,8'b0} + {row,6'b0} + col, all zero-extended to ADDR_W.
  - MemWe <= 0.
- Free slot with WriteReq = 1, and WRITE_IN_BLANK_ONLY = 0 or outside the active region:
  - MemAddr <= WriteAddr, MemWData <= WriteData.
  - MemWe <= 1 if WriteAddr < 76800, else 0.
  - WriteAck <= 1. WriteDropped <= 1 if the address is out of range.
- Free slot with no request: MemWe <= 0, MemAddr holds.
- Writer rules:
  - At most one ack per request cycle. The writer may change WriteAddr/WriteData, or deassert WriteReq, in the cycle after the ack.
  - A request that is still high after an ack is treated as a new request, so back-to-back writes are possible.
- Pixel pipeline, 4-state tag shift register:
  - Read command registered at cycle t+1, RAM data at t+2.
  - PixelOut <= MemRData at t+3 and held through t+4, so each stored pixel lasts 2 clocks.
  - PixelValid mirrors "active" delayed by 3 cycles.
  - Downstream must delay HSync/VSync by 3 cycles.
  - PixelOut = 0 whenever PixelValid = 0.
- Wrap-around: (H=799, V=524) -> (0,0) needs no special handling; the address is recomputed from the counters every cycle.
- Blanking (H >= 640 or V >= 480): every cycle is a free slot, up to 1 write per clock.
- Simultaneous events: the display always wins its slot. A writer is never acked in a display slot.
- Reset:
  - MemAddr = 0, MemWe = 0, MemWData = 0, WriteAck = 0, WriteDropped = 0, PixelOut = 0, PixelValid = 0; pipeline tags cleared.
  - Reset mid-request: no ack is issued during reset. A request still high afterwards is served at the first eligible free slot.
  - Reset mid-line: PixelValid stays 0 until the pipeline refills, 3 cycles.

Decomposition:
- Package vga_pkg: H_ACTIVE = 640, V_ACTIVE = 480, H_TOTAL = 800, V_TOTAL = 525, FB_W, FB_H, FB_SIZE = 76800, pixel_t (logic [7:0]), vaddr_t (logic [16:0]), slot_e {SLOT_DISPLAY, SLOT_WRITE, SLOT_IDLE}.
- One natural sub-module, vga_fb_addr: combinational (H,V) -> linear address, using shifts and adds, no multiplier.

Test Plan:
- Reset held 3 cycles with WriteReq = 1 -> all outputs 0, no WriteAck; first ack at the first free slot after Reset falls.
- Counters at (H=10, V=6), RAM preloaded addr 965 = 0xA5 -> MemAddr = 965 one cycle later; PixelOut = 0xA5 with PixelValid = 1 for 2 clocks starting 3 cycles after H=10.
- WriteReq held from H=100 (V=20, active, WRITE_IN_BLANK_ONLY = 0) -> ack at H=101 only; MemWe = 1 next cycle; never acked at an even H.
- WRITE_IN_BLANK_ONLY = 1, WriteReq raised at H=200, V=10 -> no ack until H=640; then one ack per clock for a held request.
- WriteAddr = 76800 -> WriteAck and WriteDropped both pulse, MemWe stays 0, RAM unchanged.
- Full frame through wrap (799,524) -> (0,0) -> exactly 307200 cycles with PixelValid = 1 per frame; no display slot ever has MemWe = 1.
